calc_input_conditioner: RTL and testbench

Conditions the raw DE2 board controls for the calculator: 18 slide switches, an ENTER key and a CLEAR key. Produces the 19-bit word that drives the `in_port` of the Nios II input PIO. Switches are synchronised; keys are synchronised and debounced. Each accepted key press updates a captured operand/opcode snapshot and flips a toggle bit, so software can detect a new entry by polling the PIO.

---
 rtl/calc_input_conditioner_if.sv | 11 +
 rtl/calc_input_conditioner.sv | 78 +++++++
 tb/tb_calc_input_conditioner.sv | 123 ++++++++++++
 3 files changed

// File: rtl/calc_input_conditioner_if.sv
// Board-side control bundle for the calculator input conditioner.
// The board or bench drives the raw controls and the conditioner drives the PIO word.
interface calc_input_conditioner_if;
  logic [17:0] sw;
  logic        key_enter_n;
  logic        key_clear_n;
  logic [18:0] out_port;

  modport master (output sw, output key_enter_n, output key_clear_n, input out_port);
  modport slave  (input sw, input key_enter_n, input key_clear_n, output out_port);
endinterface

// File: rtl/calc_input_conditioner.sv
// Synchronises the DE2 switches and keys, debounces the keys, and captures an
// operand/opcode snapshot with an entry toggle on each accepted press.
module calc_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input logic                     clk,
  input logic                     reset,
  calc_input_conditioner_if.slave bus
);

  localparam int              CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // Key index 0 is ENTER and index 1 is CLEAR throughout.
  logic [17:0]         r_sw_m, r_sw_s;
  logic [1:0]          r_key_m, r_key_s;
  logic [1:0]          r_stable, r_stable_d;
  logic [1:0][CW-1:0]  r_cnt;
  logic [18:0]         r_out;
  logic [1:0]          w_raw_key;
  logic [1:0]          w_press;

  assign w_raw_key = {bus.key_clear_n, bus.key_enter_n};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, which makes the two-stage synchroniser behave as two stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sw_m  <= '0;
      r_sw_s  <= '0;
      r_key_m <= 2'b11;
      r_key_s <= 2'b11;
    end else begin
      r_sw_m  <= bus.sw;
      r_sw_s  <= r_sw_m;
      r_key_m <= w_raw_key;
      r_key_s <= r_key_m;
    end
  end

  // A level is accepted only after it differs from the stable value for
  // DEBOUNCE_CYCLES consecutive edges; any return to the stable level restarts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stable   <= 2'b11;
      r_stable_d <= 2'b11;
      r_cnt      <= '0;
    end else begin
      r_stable_d <= r_stable;
      for (int i = 0; i < 2; i++) begin
        if (r_key_s[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_stable[i] <= r_key_s[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Only a falling stable level counts as a press; releases are ignored.
  assign w_press = r_stable_d & ~r_stable;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out <= '0;
    end else if (w_press[1]) begin
      r_out <= {~r_out[18], 18'h0};
    end else if (w_press[0]) begin
      r_out <= {~r_out[18], r_sw_s};
    end
  end

  assign bus.out_port = r_out;

endmodule

// File: tb/tb_calc_input_conditioner.sv
// Directed bench for calc_input_conditioner with DEBOUNCE_CYCLES=4.
// Expected words are hand-computed from the capture and timing rules.
module tb_calc_input_conditioner;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_mis = 0;

  calc_input_conditioner_if u_if ();

  calc_input_conditioner #(.DEBOUNCE_CYCLES(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
    end
  endtask

  initial begin
    reset            = 1'b1;
    u_if.sw          = 18'h3FFFF;
    u_if.key_enter_n = 1'b1;
    u_if.key_clear_n = 1'b1;
    step(2);
    check("reset_value", u_if.out_port, 19'h00000);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("reset_idle", u_if.out_port, 19'h00000);
    end

    // ENTER held: first sampled at edge 1, captured exactly at edge 7.
    u_if.sw          = 18'h200A5;
    u_if.key_enter_n = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step(1);
      check("enter_wait", u_if.out_port, 19'h00000);
    end
    step(1);
    check("enter_capture", u_if.out_port, 19'h600A5);
    u_if.key_enter_n = 1'b1;
    u_if.sw          = 18'h1FFFF;
    step(12);
    check("enter_release_sw_change", u_if.out_port, 19'h600A5);

    // Bounce: 3 low, 2 high, 3 low, then high -> no event.
    u_if.key_enter_n = 1'b0; step(3);
    u_if.key_enter_n = 1'b1; step(2);
    u_if.key_enter_n = 1'b0; step(3);
    check("bounce_mid", u_if.out_port, 19'h600A5);
    u_if.key_enter_n = 1'b1; step(12);
    check("bounce_reject", u_if.out_port, 19'h600A5);

    // A 4-cycle pulse is just long enough: one update, toggle 1->0.
    u_if.sw          = 18'h200A5;
    u_if.key_enter_n = 1'b0; step(4);
    u_if.key_enter_n = 1'b1; step(12);
    check("pulse4_accept", u_if.out_port, 19'h200A5);
    u_if.key_enter_n = 1'b0; step(4);
    u_if.key_enter_n = 1'b1; step(12);
    check("pulse4_again", u_if.out_port, 19'h600A5);

    // CLEAR zeroes data and flips the toggle.
    u_if.key_clear_n = 1'b0; step(4);
    u_if.key_clear_n = 1'b1; step(12);
    check("clear_press", u_if.out_port, 19'h00000);
    u_if.sw          = 18'h01234;
    u_if.key_enter_n = 1'b0; step(4);
    u_if.key_enter_n = 1'b1; step(12);
    check("enter_after_clear", u_if.out_port, 19'h41234);

    // Simultaneous presses: CLEAR wins, toggle flips once.
    u_if.key_enter_n = 1'b0;
    u_if.key_clear_n = 1'b0;
    step(6);
    check("both_wait", u_if.out_port, 19'h41234);
    step(1);
    check("both_clear_wins", u_if.out_port, 19'h00000);
    u_if.key_enter_n = 1'b1;
    u_if.key_clear_n = 1'b1;
    step(12);
    check("both_release", u_if.out_port, 19'h00000);

    // Reset at edge 4 of a debounce with the key held; press reaccepted at edge 11.
    u_if.sw          = 18'h0ABCD;
    u_if.key_enter_n = 1'b0;
    step(3);
    reset = 1'b1;
    step(1);
    check("rst_mid_edge4", u_if.out_port, 19'h00000);
    reset = 1'b0;
    for (int e = 5; e <= 10; e++) begin
      step(1);
      check("rst_mid_wait", u_if.out_port, 19'h00000);
    end
    step(1);
    check("rst_mid_capture", u_if.out_port, 19'h4ABCD);
    u_if.key_enter_n = 1'b1;
    step(12);
    check("rst_mid_release", u_if.out_port, 19'h4ABCD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
